// File: rtl/mem_loader.sv
// Streams up to 32 bytes into a memory, keeping a running sum of what was
// accepted. It then reads every loaded word back and flags an error when the
// sum of the readback does not match.
`timescale 1ns/1ps
module mem_loader #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] load_len,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DRAIN, FINISH} state_t;

  state_t     state, state_nxt;
  logic [4:0] wr_ptr, rd_ptr, last_idx;
  logic [7:0] sum_in, sum_rb, sum_rb_add;
  logic       rd_pend, err_q, len_ok, xfer;

  assign len_ok     = (load_len != 6'd0) && (load_len <= 6'(DEPTH));
  assign sum_rb_add = sum_rb + mem_rdata;
  assign busy       = (state != IDLE);
  assign error      = err_q;
  assign checksum   = sum_in;

  // State register; reset drops straight back to IDLE from anywhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and memory/handshake outputs; abort outranks a transfer
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = len_ok ? LOAD : FINISH;
      end
      LOAD: begin
        in_ready = 1'b1;
        xfer     = in_valid && !abort;
        if (abort) begin
          state_nxt = IDLE;
        end else if (xfer) begin
          mem_write = 1'b1;
          mem_addr  = wr_ptr;
          mem_wdata = in_data;
          if (wr_ptr == last_idx) state_nxt = VERIFY;
        end
      end
      VERIFY: begin
        mem_read = 1'b1;
        mem_addr = rd_ptr;
        if (abort)                  state_nxt = IDLE;
        else if (rd_ptr == last_idx) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = abort ? IDLE : FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remembers that a read was issued last cycle, so its data is due now
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_pend <= 1'b0;
    else     rd_pend <= mem_read;
  end

  // Pointers, both sums and the sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_idx <= '0;
      sum_in   <= '0;
      sum_rb   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              wr_ptr   <= '0;
              rd_ptr   <= '0;
              sum_in   <= '0;
              sum_rb   <= '0;
              last_idx <= load_len[4:0] - 5'd1;
              err_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            err_q <= 1'b1;
          end else if (xfer) begin
            wr_ptr <= wr_ptr + 5'd1;
            sum_in <= sum_in + in_data;
          end
        end
        VERIFY: begin
          if (abort) begin
            err_q <= 1'b1;
          end else begin
            rd_ptr <= rd_ptr + 5'd1;
            if (rd_pend) sum_rb <= sum_rb_add;
          end
        end
        DRAIN: begin
          if (abort) begin
            err_q <= 1'b1;
          end else begin
            sum_rb <= sum_rb_add;
            if (sum_rb_add != sum_in) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomised directed bench for mem_loader: a byte-addressed memory with an
// optional readback fault, a bus monitor, and a reference model that works
// from the list of bytes offered.
`timescale 1ns/1ps
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid;
  logic [5:0] load_len;
  logic [7:0] in_data;
  logic       in_ready, mem_read, mem_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy, done, error;
  logic [7:0] checksum;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  mem [32];
  logic [7:0]  bytes [32];
  logic        corrupt = 1'b0;
  logic [12:0] wlog [$];
  logic [4:0]  rlog [$];
  int both_cnt = 0, idle_bad = 0, done_cnt = 0, rst_en_bad = 0;
  logic [7:0] exp_last_sum;
  int len, d0, bad;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .error(error), .checksum(checksum)
  );

  // Memory model: synchronous write, one-cycle read, optional bit flip on word 2
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr] ^ ((corrupt && mem_addr == 5'd2) ? 8'h01 : 8'h00);
  end

  // Bus monitor sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && mem_write) wlog.push_back({mem_addr, mem_wdata});
    if (!rst && mem_read)  rlog.push_back(mem_addr);
    if (mem_read && mem_write) both_cnt++;
    if (!mem_read && !mem_write && (mem_addr != 5'd0 || mem_wdata != 8'd0)) idle_bad++;
    if (rst && (mem_read || mem_write)) rst_en_bad++;
    if (done) done_cnt++;
  end

  // Watchdog so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete load of bytes[0..n-1]; expectations come from the byte list
  task automatic applyStimulus(input int n, input bit gaps, input bit poke_start);
    int i = 0;
    int budget = 0;
    int lat = 1;
    int errs = 0;
    int dstart;
    logic [7:0] exp_sum = 8'd0;
    logic [7:0] rb_sum = 8'd0;
    wlog.delete();
    rlog.delete();
    dstart = done_cnt;
    start = 1'b1;
    load_len = 6'(n);
    tick;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    while (i < n && budget < 4000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = bytes[i];
      if (poke_start) begin
        start    = 1'($urandom_range(0, 1));
        load_len = 6'($urandom_range(0, 63));
      end
      if (in_valid && in_ready) i++;
      tick;
      budget++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = 8'd0;
    checkOutput("bytes_accepted", i, n);
    while (done !== 1'b1 && lat < 200) begin
      tick;
      lat++;
    end
    checkOutput("done_latency", lat, n + 2);
    for (int k = 0; k < n; k++) begin
      exp_sum += bytes[k];
      rb_sum  += bytes[k] ^ ((corrupt && k == 2) ? 8'h01 : 8'h00);
    end
    exp_last_sum = exp_sum;
    checkOutput("error_at_done", error, (rb_sum != exp_sum) ? 1 : 0);
    checkOutput("checksum", checksum, exp_sum);
    tick;
    checkOutput("done_single_cycle", done, 0);
    checkOutput("idle_after_done", busy, 0);
    if (wlog.size() != n) errs++;
    else for (int k = 0; k < n; k++) if (wlog[k] !== {5'(k), bytes[k]}) errs++;
    checkOutput("write_sequence", errs, 0);
    errs = 0;
    if (rlog.size() != n) errs++;
    else for (int k = 0; k < n; k++) if (rlog[k] !== 5'(k)) errs++;
    checkOutput("read_sequence", errs, 0);
    checkOutput("done_pulses", done_cnt - dstart, 1);
  endtask

  // Illegal length: immediate finish with error, no memory traffic
  task automatic badLen(input int n);
    wlog.delete();
    rlog.delete();
    start = 1'b1;
    load_len = 6'(n);
    tick;
    start = 1'b0;
    checkOutput("badlen_done", done, 1);
    checkOutput("badlen_error", error, 1);
    tick;
    checkOutput("badlen_done_low", done, 0);
    checkOutput("badlen_idle", busy, 0);
    checkOutput("badlen_no_mem", wlog.size() + rlog.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = 8'd0; load_len = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {in_ready, mem_read, mem_write, mem_addr, mem_wdata, busy, done, error, checksum}, 0);
    rst = 1'b0;
    tick;

    $display("[TB] four fixed bytes back-to-back");
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("checksum_aa", checksum, 8'hAA);
    checkOutput("error_clear", error, 0);

    $display("[TB] full 32 bytes of 0xFF with gaps");
    for (int k = 0; k < 32; k++) bytes[k] = 8'hFF;
    applyStimulus(32, 1'b1, 1'b0);
    checkOutput("checksum_e0", checksum, 8'hE0);
    bad = 0;
    for (int k = 0; k < 32; k++) if (mem[k] !== 8'hFF) bad++;
    checkOutput("mem_all_ff", bad, 0);

    $display("[TB] random loads with start toggled while busy");
    repeat (4) begin
      len = $urandom_range(1, 32);
      for (int k = 0; k < 32; k++) bytes[k] = 8'($urandom);
      applyStimulus(len, 1'b1, 1'b1);
    end
    repeat (5) tick;
    checkOutput("checksum_holds", checksum, exp_last_sum);

    $display("[TB] corrupted readback");
    corrupt = 1'b1;
    for (int k = 0; k < 32; k++) bytes[k] = 8'($urandom);
    applyStimulus(6, 1'b1, 1'b0);
    checkOutput("corrupt_sticky", error, 1);
    corrupt = 1'b0;
    for (int k = 0; k < 32; k++) bytes[k] = 8'($urandom);
    applyStimulus(3, 1'b0, 1'b0);

    $display("[TB] illegal lengths");
    badLen(0);
    badLen(33);

    $display("[TB] abort after two of five bytes");
    wlog.delete();
    d0 = done_cnt;
    for (int k = 0; k < 32; k++) bytes[k] = 8'($urandom);
    start = 1'b1; load_len = 6'd5;
    tick;
    start = 1'b0;
    in_valid = 1'b1; in_data = bytes[0];
    tick;
    in_data = bytes[1];
    tick;
    in_data = 8'h99; abort = 1'b1;
    #1;
    checkOutput("abort_no_write", mem_write, 0);
    tick;
    abort = 1'b0; in_valid = 1'b0;
    checkOutput("abort_busy_low", busy, 0);
    checkOutput("abort_error", error, 1);
    repeat (8) tick;
    checkOutput("abort_no_done", done_cnt - d0, 0);
    bad = 0;
    if (wlog.size() != 2) bad++;
    else for (int k = 0; k < 2; k++) if (wlog[k] !== {5'(k), bytes[k]}) bad++;
    checkOutput("abort_writes", bad, 0);

    $display("[TB] abort ignored in IDLE and FINISH");
    d0 = done_cnt;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checkOutput("abort_idle_busy", busy, 0);
    checkOutput("abort_idle_error", error, 1);
    start = 1'b1; load_len = 6'd0;
    tick;
    start = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
    checkOutput("abort_finish_done", done_cnt - d0, 1);

    $display("[TB] reset during verify");
    for (int k = 0; k < 8; k++) bytes[k] = 8'(k + 1);
    start = 1'b1; load_len = 6'd8;
    tick;
    start = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = bytes[k];
      tick;
    end
    in_valid = 1'b0;
    tick;
    checkOutput("in_verify", mem_read, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_mid_verify",
                {in_ready, mem_read, mem_write, mem_addr, mem_wdata, busy, done, error, checksum}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick;
    bytes[0] = 8'h5A;
    applyStimulus(1, 1'b0, 1'b0);
    checkOutput("post_reset_checksum", checksum, 8'h5A);
    checkOutput("post_reset_error", error, 0);

    checkOutput("rw_exclusive", both_cnt, 0);
    checkOutput("idle_bus_zero", idle_bad, 0);
    checkOutput("no_enable_in_reset", rst_en_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
